// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard by pulling the open-drain clock and
// data lines low through active-high enables. The line levels come back in
// through the same synchronizers that feed the receive decoder.
// Frame on the wire: start(0), d0..d7, odd parity, stop(1), then the device ACK.
// Every output is a flop, so the pad enables cannot glitch while the state changes.
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       ps_clk_in,
  input  logic       ps_data_in,
  output logic       ps_clk_oe_out,
  output logic       ps_data_oe_out,
  output logic       done_out,
  output logic       error_out
);

  // Each counter only ever holds values up to its limit minus one.
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [9:0]       frame, frame_d;      // {stop, parity, d7..d0}
  logic [3:0]       idx, idx_d;          // next frame bit to present
  logic [INH_W-1:0] inh_cnt, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt, to_cnt_d;
  logic             err_flag, err_d;
  logic             clk_prev;
  logic             fall;
  logic             to_hit;
  logic             data_bit_d;          // data pull-low value held across SEND
  logic             ready_d, clk_oe_d, data_oe_d, done_d, error_d;

  assign fall   = clk_prev & ~ps_clk_in;
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // State, datapath and registered outputs; reset releases both lines at once
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= S_IDLE;
      frame          <= '0;
      idx            <= '0;
      inh_cnt        <= '0;
      to_cnt         <= '0;
      err_flag       <= 1'b0;
      clk_prev       <= 1'b1;
      ready_out      <= 1'b1;
      ps_clk_oe_out  <= 1'b0;
      ps_data_oe_out <= 1'b0;
      done_out       <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      state          <= state_d;
      frame          <= frame_d;
      idx            <= idx_d;
      inh_cnt        <= inh_cnt_d;
      to_cnt         <= to_cnt_d;
      err_flag       <= err_d;
      clk_prev       <= ps_clk_in;
      ready_out      <= ready_d;
      ps_clk_oe_out  <= clk_oe_d;
      ps_data_oe_out <= data_oe_d;
      done_out       <= done_d;
      error_out      <= error_d;
    end
  end

  // Next state and datapath updates. The outputs are decoded from the next
  // state, so they take effect in the same cycle as the new state.
  always_comb begin
    state_d    = state;
    frame_d    = frame;
    idx_d      = idx;
    inh_cnt_d  = inh_cnt;
    to_cnt_d   = to_cnt;
    err_d      = err_flag;
    data_bit_d = ps_data_oe_out;

    case (state)
      S_IDLE: begin
        if (valid_in) begin
          frame_d   = {1'b1, ~^data_in, data_in};
          idx_d     = '0;
          inh_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          inh_cnt_d = '0;
          state_d   = S_REQUEST;
        end else begin
          inh_cnt_d = inh_cnt + 1'b1;
        end
      end

      // The start bit is already on the data line. Releasing the clock here
      // hands clocking over to the device.
      S_REQUEST: begin
        to_cnt_d = '0;
        idx_d    = '0;
        state_d  = S_SEND;
      end

      // The device samples on its rising edge, so each new bit goes out on the
      // falling edge before it.
      S_SEND: begin
        if (fall) begin
          data_bit_d = ~frame[idx];
          to_cnt_d   = '0;
          if (idx == 4'd9) state_d = S_WAIT_ACK;
          else             idx_d   = idx + 4'd1;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end

      // Both lines are released. The device pulls data low to ACK before the 11th fall.
      S_WAIT_ACK: begin
        if (fall) begin
          err_d    = ps_data_in;
          to_cnt_d = '0;
          state_d  = S_WAIT_IDLE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        if (ps_clk_in && ps_data_in) begin
          state_d = S_DONE;
        end else if (fall) begin
          to_cnt_d = '0;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    ready_d   = (state_d == S_IDLE);
    clk_oe_d  = (state_d == S_INHIBIT) || (state_d == S_REQUEST);
    data_oe_d = (state_d == S_REQUEST) || ((state_d == S_SEND) && data_bit_d);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_DONE) && err_d;
  end

endmodule

// File: doc/ps2_transmitter.md
Name: ps2_transmitter

Overview:
Host-to-device PS/2 transmitter. It is the opposite direction of the ps2_decoder receive path and sends command bytes to the keyboard, e.g. 0xED (set LEDs) or 0xFF (reset). It drives the open-drain PS/2 clock and data lines through active-high pull-low enables. It senses the lines through the same 2-flop synchronizer outputs that feed the decoder, and the top level muxes the enables onto the tri-state pads.

Parameters:
INHIBIT_CYCLES, 10000, cycles the clock line is held low before the request-to-send (100 us at 100 MHz)
TIMEOUT_CYCLES, 2000000, max clk_in cycles between device clock falling edges, or waiting for bus idle, before abort (20 ms)

Ports:
clk_in  input  1  system clock, 100 MHz
rst_in  input  1  asynchronous, active-low reset
data_in  input  8  command byte to send
valid_in  input  1  request; accepted when valid_in && ready_out
ready_out  output  1  high only in IDLE
ps_clk_in  input  1  synchronized PS/2 clock line level
ps_data_in  input  1  synchronized PS/2 data line level
ps_clk_oe_out  output  1  1 = pull clock line low
ps_data_oe_out  output  1  1 = pull data line low
done_out  output  1  one-cycle pulse at end of every transaction (success or failure)
error_out  output  1  one-cycle pulse coincident with done_out on NACK or timeout

Behaviour:
- Reset (rst_in low, async):
  - state IDLE; ready_out=1; both oe=0; done_out=0; error_out=0.
  - Shift register, bit index and counters cleared; clk_prev=1.
  - Reset mid-transfer releases both lines immediately.
- Falling-edge detect: fall = clk_prev & ~ps_clk_in; clk_prev <= ps_clk_in every cycle.
- Accept: in IDLE with valid_in=1, latch frame {stop=1, parity, data_in[7:0]}.
  - parity = ~^data_in (odd parity).
  - Next state INHIBIT; ready_out drops the following cycle.
  - valid_in is ignored outside IDLE.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQUEST.
- REQUEST: clk_oe=1, data_oe=1 (start bit) for exactly 1 cycle, then SEND with clk_oe=0 and data_oe held at 1. Timeout counter cleared.
- SEND: on each fall, present the next frame bit. data_oe = ~bit. Order: d0..d7, parity, stop.
  - The 10th fall presents stop (data_oe=0); the machine then enters WAIT_ACK.
  - The device samples each bit on the rising edge, so the bit is held until the next fall.
- WAIT_ACK: both oe=0. On the next fall (11th), sample ps_data_in: 0 = ACK, 1 = NACK (error flag set). Then WAIT_IDLE.
- WAIT_IDLE: wait until ps_clk_in=1 && ps_data_in=1 in the same cycle, then DONE.
- DONE: single cycle. done_out=1; error_out=error flag. Then IDLE.
- Timeout:
  - Counter increments every cycle in SEND, WAIT_ACK and WAIT_IDLE. It clears on each fall and on entering WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: both oe=0 immediately, error flag set, go to DONE.
- Transaction latency (clk_in cycles): accept→first cycle of INHIBIT is 1; INHIBIT is INHIBIT_CYCLES; REQUEST is 1. Device clocking determines the rest.
- Outputs are registered; oe outputs are glitch-free (no combinational decode of state to pads).

Test Plan:
- Send 0xED (INHIBIT_CYCLES=10, device model ~12.5 kHz, ACK):
  - clk_oe high 10 cycles, data_oe high from REQUEST.
  - Bits sampled on device rising edges: 0,1,0,1,1,0,1,1,1 (start, d0..d7).
  - Parity=1, stop=1, ACK low.
  - done_out=1, error_out=0, ready_out=1 next cycle.
- Send 0x00: parity=1; data_oe=1 for start and d0..d7; data_oe=0 for parity and stop; done_out with error_out=0.
- NACK: device leaves data high on the 11th fall → done_out=1 and error_out=1 in the same cycle.
- Timeout (TIMEOUT_CYCLES=1000): device stops clocking after 4 falls → 1000 cycles later both oe=0, done_out=1, error_out=1, back to IDLE.
- Busy: pulse valid_in with 0x55 during SEND of 0xFF → ignored; only 0xFF appears on the line; exactly one done_out.
- Reset: assert rst_in low mid-SEND (after 5 falls) → both oe=0 and ready_out=1 asynchronously; release, then send 0xF4 → completes normally with error_out=0.
